cpu_sequencer: RTL

Fetch/decode/issue controller for the 2-bit-opcode ALU execute stage of the first CPU. Fetches 10-bit instruction words from an external instruction memory over a req/ack handshake, decodes them, and drives opcode and register addresses to the execute stage. It then holds those fields stable for a fixed execute latency before advancing the PC. It also handles HALT, NOP and illegal-instruction termination and reports status to the top level.

---
 rtl/cpu_pkg.sv | 46 ++++
 rtl/cpu_seq_decode.sv | 32 +++
 rtl/cpu_sequencer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU sequencer: instruction field layout,
// instruction classes, ALU opcodes and the sequencer state encoding.
package cpu_pkg;

  localparam int INSTR_W = 10;

  // Instruction word layout: [9:8] class, [7:6] op, [5:4] dest, [3:2] src1, [1:0] src2
  localparam int CLS_MSB  = 9;
  localparam int CLS_LSB  = 8;
  localparam int OP_MSB   = 7;
  localparam int OP_LSB   = 6;
  localparam int DST_MSB  = 5;
  localparam int DST_LSB  = 4;
  localparam int SRC1_MSB = 3;
  localparam int SRC1_LSB = 2;
  localparam int SRC2_MSB = 1;
  localparam int SRC2_LSB = 0;

  localparam logic [1:0] CLS_ALU  = 2'b00;
  localparam logic [1:0] CLS_HALT = 2'b01;
  localparam logic [1:0] CLS_NOP  = 2'b10;
  localparam logic [1:0] CLS_RSVD = 2'b11;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_ISSUE  = 3'd3,
    ST_WAIT   = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  // Fields handed to the execute stage.
  typedef struct packed {
    logic [1:0] op;
    logic [1:0] dest;
    logic [1:0] src1;
    logic [1:0] src2;
  } alu_fields_t;

endpackage

// File: rtl/cpu_seq_decode.sv
// Combinational instruction decoder.
// Ports:
//   instr   in  instruction word
//   is_alu / is_halt / is_nop  class flags
//   is_rsvd out reserved class (illegal instruction)
//   fields  out op / dest / src1 / src2 fields
module cpu_seq_decode
  import cpu_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output logic               is_alu,
  output logic               is_halt,
  output logic               is_nop,
  output logic               is_rsvd,
  output alu_fields_t        fields
);

  logic [1:0] cls;

  always_comb begin
    cls         = instr[CLS_MSB:CLS_LSB];
    is_alu      = (cls == CLS_ALU);
    is_halt     = (cls == CLS_HALT);
    is_nop      = (cls == CLS_NOP);
    is_rsvd     = (cls == CLS_RSVD);
    fields.op   = instr[OP_MSB:OP_LSB];
    fields.dest = instr[DST_MSB:DST_LSB];
    fields.src1 = instr[SRC1_MSB:SRC1_LSB];
    fields.src2 = instr[SRC2_MSB:SRC2_LSB];
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/decode/issue controller for the 2-bit-opcode ALU execute stage.
// Fetches instruction words over a req/ack handshake, decodes them, issues
// ALU ops with a one-cycle exec_en strobe and holds the fields for EXEC_LAT
// cycles before advancing the PC. Handles NOP, HALT and reserved words.
// Ports:
//   clk, reset_n (async, active low)
//   start, pc_start                 begin execution (IDLE/HALT only)
//   imem_req/addr/ack/data          instruction fetch handshake
//   exec_en, op_code, src_addr1/2, dest_addr   execute stage issue
//   busy, halted, illegal, pc       status
// Optional feature: define CPU_SEQ_PERF_CNT_EN to add a saturating 16-bit
// retired_cnt output counting completed ALU instructions.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_W     = 4,
  parameter int EXEC_LAT = 3   // 1..15
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [PC_W-1:0]    pc_start,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               exec_en,
  output logic [1:0]         op_code,
  output logic [1:0]         src_addr1,
  output logic [1:0]         src_addr2,
  output logic [1:0]         dest_addr,
  output logic               busy,
  output logic               halted,
  output logic               illegal,
  output logic [PC_W-1:0]    pc
`ifdef CPU_SEQ_PERF_CNT_EN
  ,
  output logic [15:0]        retired_cnt
`endif
);

  localparam int CNT_W = 4;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  alu_fields_t        fields_q, fields_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               illegal_q, illegal_d;

  logic        dec_alu, dec_halt, dec_nop, dec_rsvd;
  alu_fields_t dec_fields;

  cpu_seq_decode u_decode (
    .instr   (ir_q),
    .is_alu  (dec_alu),
    .is_halt (dec_halt),
    .is_nop  (dec_nop),
    .is_rsvd (dec_rsvd),
    .fields  (dec_fields)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_HALT: if (start) state_d = ST_FETCH;
      ST_FETCH:         if (imem_ack) state_d = ST_DECODE;
      ST_DECODE: begin
        if (dec_alu)                  state_d = ST_ISSUE;
        else if (dec_nop)             state_d = ST_FETCH;
        else if (dec_halt || dec_rsvd) state_d = ST_HALT;
        else                          state_d = ST_HALT;
      end
      ST_ISSUE:         state_d = ST_WAIT;
      ST_WAIT:          if (wait_cnt_q == '0) state_d = ST_FETCH;
      default:          state_d = ST_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    imem_req = (state_q == ST_FETCH);
    exec_en  = (state_q == ST_ISSUE);
    halted   = (state_q == ST_HALT);
    busy     = (state_q != ST_IDLE) && (state_q != ST_HALT);
  end

  // Datapath next values
  always_comb begin
    pc_d       = pc_q;
    ir_d       = ir_q;
    fields_d   = fields_q;
    wait_cnt_d = wait_cnt_q;
    illegal_d  = illegal_q;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          pc_d      = pc_start;
          illegal_d = 1'b0;
        end
      end
      ST_FETCH: if (imem_ack) ir_d = imem_data;
      ST_DECODE: begin
        // Fields only change when a new ALU op is about to issue, so they
        // stay stable through ISSUE and every WAIT cycle.
        if (dec_alu)  fields_d  = dec_fields;
        if (dec_nop)  pc_d      = pc_q + PC_W'(1);
        if (dec_rsvd) illegal_d = 1'b1;
      end
      ST_ISSUE: wait_cnt_d = CNT_W'(EXEC_LAT - 1);
      ST_WAIT: begin
        if (wait_cnt_q == '0) pc_d = pc_q + PC_W'(1);
        else                  wait_cnt_d = wait_cnt_q - CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q       <= '0;
      ir_q       <= '0;
      fields_q   <= '0;
      wait_cnt_q <= '0;
      illegal_q  <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      fields_q   <= fields_d;
      wait_cnt_q <= wait_cnt_d;
      illegal_q  <= illegal_d;
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign illegal   = illegal_q;
  assign op_code   = fields_q.op;
  assign dest_addr = fields_q.dest;
  assign src_addr1 = fields_q.src1;
  assign src_addr2 = fields_q.src2;

`ifdef CPU_SEQ_PERF_CNT_EN
  logic [15:0] retired_cnt_q, retired_cnt_d;

  always_comb begin
    retired_cnt_d = retired_cnt_q;
    if ((state_q == ST_IDLE || state_q == ST_HALT) && start)
      retired_cnt_d = '0;
    else if (state_q == ST_WAIT && wait_cnt_q == '0 && retired_cnt_q != 16'hFFFF)
      retired_cnt_d = retired_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) retired_cnt_q <= '0;
    else          retired_cnt_q <= retired_cnt_d;
  end

  assign retired_cnt = retired_cnt_q;
`endif

endmodule
